seg7_scan_decoder: RTL

- Receiver side of the multiplexed 4-digit seven-segment scan bus driven by the team's clock and display blocks.
- Samples active-low an/a_to_g/dp and waits for each scan slot to settle. Decodes the segment pattern back to BCD and assembles a complete mm:ss frame.
- Used as an on-board display self-check and as a bench monitor for display-driving blocks. Outputs are registered BCD digits plus frame/error flags.

---
 rtl/seg7_pkg.sv | 48 ++++
 rtl/seg7_pattern_decode.sv | 32 +++
 rtl/seg7_scan_decoder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan bus: active-low segment
// patterns, digit slot indices, the receiver FSM states and the an decoder.
package seg7_pkg;

  // Active-low segment patterns, bit6=a ... bit0=g
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  // Digit slot index = position of the low bit in an
  localparam logic [1:0] IDX_SEC_ONES = 2'd0;
  localparam logic [1:0] IDX_SEC_TENS = 2'd1;
  localparam logic [1:0] IDX_MIN_ONES = 2'd2;
  localparam logic [1:0] IDX_MIN_TENS = 2'd3;

  // The only slot whose decimal point is lit (the mm:ss separator)
  localparam logic [1:0] DP_SLOT = IDX_MIN_ONES;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } slot_sel_t;

  // An select is valid only with exactly one digit enabled (one low bit)
  function automatic slot_sel_t decode_select(input logic [3:0] an);
    slot_sel_t sel;
    sel.valid = 1'b1;
    sel.idx   = IDX_SEC_ONES;
    case (an)
      4'b1110: sel.idx = IDX_SEC_ONES;
      4'b1101: sel.idx = IDX_SEC_TENS;
      4'b1011: sel.idx = IDX_MIN_ONES;
      4'b0111: sel.idx = IDX_MIN_TENS;
      default: sel.valid = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low a_to_g pattern back to a BCD digit.
// Anything that is not one of the ten digit glyphs is flagged illegal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] a_to_g,
  output logic       legal,
  output logic [3:0] digit
);

  // Pattern lookup; unknown glyphs report legal=0 with digit 0
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    legal = 1'b1;
    digit = 4'd0;
    case (a_to_g)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receiver for the multiplexed 4-digit seven-segment scan bus. Synchronises
// the bus, waits for each scan slot to settle, decodes it, and publishes a
// complete mm:ss frame once all four slots have been captured.
// Optional: define SEG7_RANGE_CHK_EN to reject frames whose tens digits
// exceed 5 (seg_err instead of frame_valid, outputs left unchanged).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 1024,
  parameter int TIMEOUT    = 2000000,
  parameter int CNT_W      = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [6:0] a_to_g,
  input  logic       dp,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       stale
);

  // Bus layout: {an[3:0], a_to_g[6:0], dp}
  logic [11:0] bus_s1, bus_s2, bus_prev;
  logic [3:0]  an_s;
  logic [6:0]  seg_s;
  logic        dp_s;
  logic        changed, an_changed;
  slot_sel_t   sel;

  logic [CNT_W-1:0] stab_cnt, wd_cnt;
  state_t           state, state_next;
  logic             eval, settled, legal, dp_ok, capture, bad_slot;
  logic             timeout_hit, frame_done, range_ok;
  logic [3:0]       digit;
  logic [3:0]       mask;
  logic [3:0]       shadow [4];

  // Two-flop synchroniser plus one history stage for change detection
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would collapse the chain.
    if (rst) begin
      bus_s1   <= '1;
      bus_s2   <= '1;
      bus_prev <= '1;
    end else begin
      bus_s1   <= {an, a_to_g, dp};
      bus_s2   <= bus_s1;
      bus_prev <= bus_s2;
    end
  end

  assign {an_s, seg_s, dp_s} = bus_s2;
  assign changed    = (bus_s2 != bus_prev);
  assign an_changed = (bus_s2[11:8] != bus_prev[11:8]);
  assign sel        = decode_select(an_s);

  // Stability counter: cycles the synced bus has held still, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stab_cnt <= '0;
    else if (changed)
      stab_cnt <= '0;
    else if (stab_cnt != CNT_W'(STABLE_CNT - 1))
      stab_cnt <= stab_cnt + 1'b1;
  end

  // The slot is evaluated on the edge where the counter reaches its limit
  assign settled = !changed && (stab_cnt == CNT_W'(STABLE_CNT - 2));

  seg7_pattern_decode u_pattern_decode (
    .a_to_g (seg_s),
    .legal  (legal),
    .digit  (digit)
  );

  // Decimal point must be lit (low) on the separator slot only
  assign dp_ok    = (dp_s == (sel.idx != DP_SLOT));
  assign capture  = eval && legal && dp_ok;
  assign bad_slot = eval && !(legal && dp_ok);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state: one evaluation per scan dwell
  always_comb begin
    state_next = state;
    eval       = 1'b0;
    case (state)
      IDLE:   if (sel.valid) state_next = SETTLE;
      SETTLE: begin
        if (!sel.valid) begin
          state_next = IDLE;
        end else if (settled) begin
          eval       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD:   if (an_changed) state_next = sel.valid ? SETTLE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Watchdog: cycles since the last good capture, saturating at TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd_cnt <= '0;
    else if (capture)
      wd_cnt <= '0;
    else if (wd_cnt != CNT_W'(TIMEOUT))
      wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout_hit = !capture && (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign frame_done  = (mask == 4'hF);

`ifdef SEG7_RANGE_CHK_EN
  assign range_ok = (shadow[IDX_SEC_TENS] <= 4'd5) && (shadow[IDX_MIN_TENS] <= 4'd5);
`else
  assign range_ok = 1'b1;
`endif

  // Shadow digits and the captured-slot mask
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the four-entry shadow array is plain flops, so it is reset with
    // the rest of the state; a RAM-backed array would not be.
    if (rst) begin
      mask <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else begin
      if (capture) shadow[sel.idx] <= digit;
      if (frame_done)
        mask <= '0;
      else if (capture)
        mask <= mask | (4'b0001 << sel.idx);
      else if (bad_slot || timeout_hit)
        mask <= '0;
    end
  end

  // Output registers: frame publish, error pulse and stale level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_ones    <= '0;
      sec_tens    <= '0;
      min_ones    <= '0;
      min_tens    <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      stale       <= 1'b1;
    end else begin
      frame_valid <= 1'b0;
      seg_err     <= bad_slot;
      if (frame_done) begin
        if (range_ok) begin
          sec_ones    <= shadow[IDX_SEC_ONES];
          sec_tens    <= shadow[IDX_SEC_TENS];
          min_ones    <= shadow[IDX_MIN_ONES];
          min_tens    <= shadow[IDX_MIN_TENS];
          frame_valid <= 1'b1;
          stale       <= 1'b0;
        end else begin
          seg_err     <= 1'b1;
        end
      end else if (timeout_hit) begin
        stale <= 1'b1;
      end
    end
  end

endmodule
